// File: rtl/pyhdl_via_call_arbiter_if.sv
// Call-channel bundle for pyhdl_via_call_arbiter: requester side, bridge side.
// master = arbiter view; slave = requesters plus bridge view.
interface pyhdl_via_call_arbiter_if #(
   parameter int N_REQ  = 4,
   parameter int DATA_W = 64,
   parameter int METH_W = 8
);
   localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   // requester call side
   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ-1:0]        req_ready;
   logic [N_REQ*METH_W-1:0] req_method;
   logic [N_REQ*DATA_W-1:0] req_data;
   // requester response side
   logic [N_REQ-1:0]        rsp_valid;
   logic [N_REQ-1:0]        rsp_ready;
   logic [DATA_W-1:0]       rsp_data;
   logic                    rsp_err;
   // bridge call side
   logic                    call_valid;
   logic                    call_ready;
   logic [IDW-1:0]          call_src;
   logic [METH_W-1:0]       call_method;
   logic [DATA_W-1:0]       call_data;
   // bridge return side
   logic                    ret_valid;
   logic                    ret_ready;
   logic [DATA_W-1:0]       ret_data;

   modport master (
      input  req_valid, req_method, req_data, rsp_ready,
      input  call_ready, ret_valid, ret_data,
      output req_ready, rsp_valid, rsp_data, rsp_err,
      output call_valid, call_src, call_method, call_data, ret_ready
   );

   modport slave (
      output req_valid, req_method, req_data, rsp_ready,
      output call_ready, ret_valid, ret_data,
      input  req_ready, rsp_valid, rsp_data, rsp_err,
      input  call_valid, call_src, call_method, call_data, ret_ready
   );
endinterface

// File: rtl/pyhdl_via_call_arbiter.sv
// Round-robin arbiter sharing one VIA bridge call port among N_REQ requesters,
// with a watchdog that converts a missing return into an error response.
// Ports: i_clock, i_reset (sync, active-high), bus (master modport),
//        o_busy (state != IDLE), o_err_count (saturating timeout count).
module pyhdl_via_call_arbiter #(
   parameter int N_REQ   = 4,
   parameter int DATA_W  = 64,
   parameter int METH_W  = 8,
   parameter int TIMEOUT = 1024
) (
   input  logic                     i_clock,
   input  logic                     i_reset,
   pyhdl_via_call_arbiter_if.master bus,
   output logic                     o_busy,
   output logic [7:0]               o_err_count
);
   localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_DELIVER
   } state_t;

   state_t              r_state;
   logic [IDW-1:0]      r_ptr;
   logic [IDW-1:0]      r_idx;
   logic [METH_W-1:0]   r_meth;
   logic [DATA_W-1:0]   r_data;
   logic [CW-1:0]       r_cnt;
   logic [DATA_W-1:0]   r_rsp_data;
   logic                r_rsp_err;
   logic [N_REQ-1:0]    r_rsp_valid;
   logic                r_call_valid;
   logic                r_ret_ready;
   logic                r_busy;
   logic [7:0]          r_err_cnt;

   logic                w_any;
   logic [IDW-1:0]      w_win;
   logic [N_REQ-1:0]    w_win_oh;
   logic [N_REQ-1:0]    w_idx_oh;
   logic [N_REQ-1:0]    w_grant;
   logic [METH_W-1:0]   w_meth;
   logic [DATA_W-1:0]   w_data;
   logic                w_rsp_hs;
   logic                w_expire;

   // Search ptr+1 .. ptr+N_REQ (mod N_REQ); iterating from the far end
   // lets the nearest asserted lane overwrite earlier candidates.
   always_comb begin : p_rr
      int j;
      j     = 0;
      w_any = 1'b0;
      w_win = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         j = int'(r_ptr) + k;
         if (j >= N_REQ) j = j - N_REQ;
         if (bus.req_valid[j[IDW-1:0]]) begin
            w_any = 1'b1;
            w_win = j[IDW-1:0];
         end
      end
   end

   always_comb begin
      w_win_oh = '0;
      w_idx_oh = '0;
      w_meth   = '0;
      w_data   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         w_win_oh[i] = (IDW'(i) == w_win);
         w_idx_oh[i] = (IDW'(i) == r_idx);
         if (IDW'(i) == w_win) begin
            w_meth = bus.req_method[i*METH_W +: METH_W];
            w_data = bus.req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // Grant is combinational in IDLE; reset masks it so nothing is accepted.
   assign w_grant  = (r_state == S_IDLE && w_any && !i_reset) ? w_win_oh : '0;
   assign w_rsp_hs = |(bus.rsp_ready & w_idx_oh);
   assign w_expire = (TIMEOUT != 0) && (r_cnt == LAST);

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state      <= S_IDLE;
         r_ptr        <= IDW'(N_REQ - 1);
         r_idx        <= '0;
         r_meth       <= '0;
         r_data       <= '0;
         r_cnt        <= '0;
         r_rsp_data   <= '0;
         r_rsp_err    <= 1'b0;
         r_rsp_valid  <= '0;
         r_call_valid <= 1'b0;
         r_ret_ready  <= 1'b0;
         r_busy       <= 1'b0;
         r_err_cnt    <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               // Returns seen here are stale and simply dropped.
               r_ret_ready <= 1'b1;
               if (w_any) begin
                  r_idx        <= w_win;
                  r_ptr        <= w_win;
                  r_meth       <= w_meth;
                  r_data       <= w_data;
                  r_call_valid <= 1'b1;
                  r_busy       <= 1'b1;
                  r_state      <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (bus.call_ready) begin
                  r_call_valid <= 1'b0;
                  r_cnt        <= '0;
                  r_state      <= S_WAIT;
               end
            end
            S_WAIT: begin
               // A return in the expiry cycle wins over the watchdog.
               if (bus.ret_valid) begin
                  r_rsp_data  <= bus.ret_data;
                  r_rsp_err   <= 1'b0;
                  r_rsp_valid <= w_idx_oh;
                  r_ret_ready <= 1'b0;
                  r_state     <= S_DELIVER;
               end else if (w_expire) begin
                  r_rsp_data  <= '0;
                  r_rsp_err   <= 1'b1;
                  r_rsp_valid <= w_idx_oh;
                  r_ret_ready <= 1'b0;
                  if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
                  r_state     <= S_DELIVER;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            S_DELIVER: begin
               if (w_rsp_hs) begin
                  r_rsp_valid <= '0;
                  r_ret_ready <= 1'b1;
                  r_busy      <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.req_ready   = w_grant;
   assign bus.rsp_valid   = r_rsp_valid;
   assign bus.rsp_data    = r_rsp_data;
   assign bus.rsp_err     = r_rsp_err;
   assign bus.call_valid  = r_call_valid;
   assign bus.call_src    = r_idx;
   assign bus.call_method = r_meth;
   assign bus.call_data   = r_data;
   assign bus.ret_ready   = r_ret_ready;
   assign o_busy          = r_busy;
   assign o_err_count     = r_err_cnt;
endmodule

// File: tb/tb_pyhdl_via_call_arbiter.sv
// Directed bench for pyhdl_via_call_arbiter (N_REQ=4, TIMEOUT=8).
// Linear sequence of steps; every check is an immediate assertion.
module tb_pyhdl_via_call_arbiter;
   logic       clk;
   logic       rst;
   logic       busy;
   logic [7:0] err_count;
   int         vectors;
   int         miscompares;
   int         w;
   int         fair_exp [6] = '{0, 1, 2, 3, 0, 1};

   pyhdl_via_call_arbiter_if #(.N_REQ(4), .DATA_W(64), .METH_W(8)) bus ();

   pyhdl_via_call_arbiter #(
      .N_REQ(4), .DATA_W(64), .METH_W(8), .TIMEOUT(8)
   ) dut (
      .i_clock    (clk),
      .i_reset    (rst),
      .bus        (bus),
      .o_busy     (busy),
      .o_err_count(err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      rst = 1'b1;
      bus.req_valid  = '0;
      bus.req_method = '0;
      bus.req_data   = '0;
      bus.rsp_ready  = '1;
      bus.call_ready = 1'b1;
      bus.ret_valid  = 1'b0;
      bus.ret_data   = '0;

      // reset state
      repeat (3) @(negedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_errcnt", err_count, 0);
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_call_valid", bus.call_valid, 0);
      chk("rst_ret_ready", bus.ret_ready, 0);
      chk("rst_rsp_err", bus.rsp_err, 0);
      @(negedge clk);
      rst = 1'b0;

      // single request, lane 2
      @(negedge clk);
      bus.req_valid = 4'b0100;
      bus.req_method[23:16] = 8'h11;
      bus.req_data[191:128] = 64'hA5;
      #1;
      chk("s_req_ready", bus.req_ready, 4'b0100);
      chk("s_idle_ret_ready", bus.ret_ready, 1);
      chk("s_busy0", busy, 0);
      @(negedge clk);
      bus.req_valid = '0;
      #1;
      chk("s_call_valid", bus.call_valid, 1);
      chk("s_call_src", bus.call_src, 2);
      chk("s_call_method", bus.call_method, 8'h11);
      chk("s_call_data", bus.call_data, 64'hA5);
      chk("s_busy1", busy, 1);
      @(negedge clk);
      bus.ret_valid = 1'b1;
      bus.ret_data = 64'h5A;
      #1;
      chk("s_wait_call_valid", bus.call_valid, 0);
      chk("s_wait_ret_ready", bus.ret_ready, 1);
      @(negedge clk);
      bus.ret_valid = 1'b0;
      #1;
      chk("s_rsp_valid", bus.rsp_valid, 4'b0100);
      chk("s_rsp_data", bus.rsp_data, 64'h5A);
      chk("s_rsp_err", bus.rsp_err, 0);
      chk("s_dlv_ret_ready", bus.ret_ready, 0);
      @(negedge clk);
      #1;
      chk("s_busy_fall", busy, 0);
      chk("s_rsp_fall", bus.rsp_valid, 0);

      // fairness: all lanes held valid after reset
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      bus.req_valid = 4'b1111;
      bus.ret_valid = 1'b1;
      bus.ret_data = 64'h1;
      for (int n = 0; n < 6; n++) begin
         w = 0;
         @(negedge clk);
         #1;
         while (!bus.call_valid && w < 12) begin
            @(negedge clk);
            #1;
            w++;
         end
         chk("fair_call_seen", bus.call_valid, 1);
         chk("fair_src", bus.call_src, fair_exp[n]);
      end
      @(negedge clk);
      rst = 1'b1;
      bus.req_valid = '0;
      bus.ret_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      // backpressure on call and response, lane 1
      bus.req_valid = 4'b0010;
      bus.req_method[15:8] = 8'h22;
      bus.req_data[127:64] = 64'h1234;
      bus.call_ready = 1'b0;
      bus.rsp_ready = 4'b1101;
      #1;
      chk("bp_req_ready", bus.req_ready, 4'b0010);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bus.req_valid = '0;
         #1;
         chk("bp_call_valid", bus.call_valid, 1);
         chk("bp_call_src", bus.call_src, 1);
         chk("bp_call_method", bus.call_method, 8'h22);
         chk("bp_call_data", bus.call_data, 64'h1234);
      end
      @(negedge clk);
      bus.call_ready = 1'b1;
      #1;
      chk("bp_call_hold", bus.call_valid, 1);
      @(negedge clk);
      bus.ret_valid = 1'b1;
      bus.ret_data = 64'h77;
      #1;
      chk("bp_call_once", bus.call_valid, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus.ret_valid = 1'b0;
         #1;
         chk("bp_rsp_valid", bus.rsp_valid, 4'b0010);
         chk("bp_rsp_data", bus.rsp_data, 64'h77);
         chk("bp_rsp_err", bus.rsp_err, 0);
      end
      @(negedge clk);
      bus.rsp_ready = 4'b1111;
      #1;
      chk("bp_rsp_hold", bus.rsp_valid, 4'b0010);
      @(negedge clk);
      #1;
      chk("bp_rsp_once", bus.rsp_valid, 0);
      chk("bp_busy0", busy, 0);
      @(negedge clk);
      #1;
      chk("bp_no_recall", bus.call_valid, 0);

      // watchdog timeout, lane 3
      @(negedge clk);
      bus.req_valid = 4'b1000;
      bus.req_method[31:24] = 8'h33;
      bus.req_data[255:192] = 64'h99;
      bus.rsp_ready = '0;
      #1;
      chk("to_req_ready", bus.req_ready, 4'b1000);
      @(negedge clk);
      bus.req_valid = '0;
      #1;
      chk("to_call_src", bus.call_src, 3);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         #1;
         chk("to_wait_rsp", bus.rsp_valid, 0);
         chk("to_wait_ret_ready", bus.ret_ready, 1);
      end
      @(negedge clk);
      #1;
      chk("to_rsp_valid", bus.rsp_valid, 4'b1000);
      chk("to_rsp_err", bus.rsp_err, 1);
      chk("to_rsp_data", bus.rsp_data, 0);
      chk("to_errcnt", err_count, 1);
      @(negedge clk);
      bus.rsp_ready = '1;
      #1;
      chk("to_rsp_hold", bus.rsp_valid, 4'b1000);
      @(negedge clk);
      #1;
      chk("to_rsp_done", bus.rsp_valid, 0);
      @(negedge clk);
      bus.ret_valid = 1'b1;
      bus.ret_data = 64'hDEAD;
      #1;
      chk("to_stale_ready", bus.ret_ready, 1);
      @(negedge clk);
      bus.ret_valid = 1'b0;
      #1;
      chk("to_stale_rsp", bus.rsp_valid, 0);
      chk("to_stale_busy", busy, 0);
      chk("to_stale_errcnt", err_count, 1);
      @(negedge clk);
      #1;
      chk("to_stale_rsp2", bus.rsp_valid, 0);

      // return in the watchdog expiry cycle, lane 0
      @(negedge clk);
      bus.req_valid = 4'b0001;
      bus.rsp_ready = '0;
      #1;
      chk("race_req_ready", bus.req_ready, 4'b0001);
      @(negedge clk);
      bus.req_valid = '0;
      #1;
      chk("race_call_src", bus.call_src, 0);
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         #1;
         chk("race_wait_rsp", bus.rsp_valid, 0);
      end
      @(negedge clk);
      bus.ret_valid = 1'b1;
      bus.ret_data = 64'hBEEF;
      @(negedge clk);
      bus.ret_valid = 1'b0;
      bus.rsp_ready = '1;
      #1;
      chk("race_rsp_valid", bus.rsp_valid, 4'b0001);
      chk("race_rsp_err", bus.rsp_err, 0);
      chk("race_rsp_data", bus.rsp_data, 64'hBEEF);
      chk("race_errcnt", err_count, 1);
      @(negedge clk);
      #1;
      chk("race_busy0", busy, 0);

      // repeated timeouts until err_count saturates
      @(negedge clk);
      bus.req_valid = 4'b0001;
      w = 0;
      #1;
      while (err_count != 8'd255 && w < 4000) begin
         @(negedge clk);
         #1;
         w++;
      end
      chk("sat_reach", err_count, 255);
      repeat (30) @(negedge clk);
      #1;
      chk("sat_hold", err_count, 255);
      bus.req_valid = '0;
      w = 0;
      while (busy && w < 20) begin
         @(negedge clk);
         #1;
         w++;
      end
      chk("sat_drain", busy, 0);

      // reset while waiting for a return
      @(negedge clk);
      bus.req_valid = 4'b0100;
      #1;
      chk("rw_req_ready", bus.req_ready, 4'b0100);
      @(negedge clk);
      bus.req_valid = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      chk("rw_busy", busy, 0);
      chk("rw_call_valid", bus.call_valid, 0);
      chk("rw_rsp_valid", bus.rsp_valid, 0);
      chk("rw_rsp_err", bus.rsp_err, 0);
      chk("rw_rsp_data", bus.rsp_data, 0);
      chk("rw_ret_ready", bus.ret_ready, 0);
      chk("rw_errcnt", err_count, 0);
      @(negedge clk);
      rst = 1'b0;
      bus.req_valid = 4'b0011;
      bus.ret_valid = 1'b1;
      bus.ret_data = 64'h5;
      #1;
      chk("rw_ptr_grant", bus.req_ready, 4'b0001);
      chk("rw_no_rsp", bus.rsp_valid, 0);
      @(negedge clk);
      #1;
      chk("rw_call_src0", bus.call_src, 0);
      w = 0;
      @(negedge clk);
      #1;
      while (!bus.call_valid && w < 12) begin
         @(negedge clk);
         #1;
         w++;
      end
      chk("rw_next_seen", bus.call_valid, 1);
      chk("rw_next_src", bus.call_src, 1);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/pyhdl_via_call_arbiter.md
Name: pyhdl_via_call_arbiter

Overview:
- Shares one HDL-to-Python call channel (the VIA bridge call port) among N_REQ HDL requesters. Only one call is outstanding at a time.
- Round-robin arbitration. Each call is issued to the bridge, and its return is routed back to the requester that originated it.
- A watchdog turns a missing Python return into an error response, so a hung Python call cannot deadlock the simulation.
- Sits between the VIA root component's call endpoint and user RTL/BFM requesters.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- DATA_W, 64, call argument and return payload width.
- METH_W, 8, method-id width.
- TIMEOUT, 1024, cycles allowed in WAIT before an error response; 0 disables the watchdog.
- IDW, $clog2(N_REQ) (min 1), requester index width.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  N_REQ  per-requester call request.
- req_ready  out  N_REQ  one-hot accept strobe.
- req_method  in  N_REQ*METH_W  flattened method ids; requester i at [i*METH_W +: METH_W].
- req_data  in  N_REQ*DATA_W  flattened arguments.
- rsp_valid  out  N_REQ  one-hot response strobe.
- rsp_ready  in  N_REQ  per-requester response accept.
- rsp_data  out  DATA_W  return payload (shared bus).
- rsp_err  out  1  response is a timeout error.
- call_valid  out  1  call to bridge valid.
- call_ready  in  1  bridge accepts call.
- call_src  out  IDW  granted requester index.
- call_method  out  METH_W  method id to bridge.
- call_data  out  DATA_W  argument to bridge.
- ret_valid  in  1  bridge return valid.
- ret_ready  out  1  arbiter accepts return.
- ret_data  in  DATA_W  return payload.
- busy  out  1  state != IDLE.
- err_count  out  8  saturating count of timeouts.

Behaviour:
- Reset (synchronous, dominant over all other inputs):
  - state=IDLE, all outputs 0, err_count=0.
  - RR pointer ptr=N_REQ-1, so requester 0 has first priority.
  - Reset mid-transaction abandons the call; no response is delivered.
- FSM states: IDLE, ISSUE, WAIT, DELIVER.
- IDLE:
  - Winner = first asserted req_valid, searching from ptr+1 upward and wrapping modulo N_REQ.
  - req_ready[winner]=1 combinationally in the same cycle; all other req_ready bits are 0.
  - On that edge: latch winner index, method and data; set ptr=winner; go to ISSUE.
  - No req_valid: stay in IDLE, req_ready=0.
  - Requesters may drop req_valid before grant; this has no effect.
- ISSUE:
  - call_valid=1; call_src, call_method and call_data come from latches and stay stable while call_ready=0.
  - On call_valid&&call_ready: go to WAIT and clear the watchdog counter.
- WAIT:
  - ret_ready=1.
  - On ret_valid: latch rsp_data=ret_data, rsp_err=0, go to DELIVER.
  - Otherwise the counter increments. When TIMEOUT!=0 and the counter reaches TIMEOUT-1: rsp_data=0, rsp_err=1, err_count+=1 (saturates at 255), go to DELIVER.
  - ret_valid in the same cycle as timeout expiry: the return wins and no error is raised.
- DELIVER:
  - rsp_valid[latched idx]=1; all other rsp_valid bits are 0.
  - rsp_data and rsp_err are held until rsp_ready[idx]; then go to IDLE and rsp_valid falls.
  - rsp_ready on non-granted lanes is ignored.
- ret_ready outside DELIVER:
  - ret_ready=1 in IDLE, ISSUE and WAIT; 0 in DELIVER.
  - ret_valid accepted outside WAIT is a stale (post-timeout) return and is discarded silently; it is never routed to a requester.
- Latency:
  - Minimum with zero-wait partners: accept at cycle 0, call at 1, return at 2, response at 3, IDLE at 4.
  - Peak throughput is one call per 4 cycles.
  - IDLE always spends at least one cycle between transactions.
- Fairness:
  - A continuously requesting lane waits for at most N_REQ-1 other transactions.
- Width rules:
  - call_src is zero-extended when N_REQ is not a power of 2.
  - The watchdog counter is $clog2(TIMEOUT+1) bits and is unused when TIMEOUT=0.

Test Plan:
- Single request: req_valid=4'b0100, method=8'h11, data=64'hA5 -> req_ready=4'b0100 in cycle 0; call_src=2, call_method=8'h11, call_data=64'hA5 in cycle 1; ret_data=64'h5A -> rsp_valid=4'b0100, rsp_data=64'h5A, rsp_err=0 in cycle 3; busy falls in cycle 4.
- Fairness: all 4 lanes held valid after reset -> grant order 0,1,2,3,0,1; no lane is granted twice before the others.
- Backpressure: call_ready=0 for 5 cycles, then rsp_ready=0 for 3 cycles -> call_* and rsp_* hold stable values; exactly one call and one response occur.
- Timeout with TIMEOUT=8, no ret_valid -> DELIVER after 8 WAIT cycles with rsp_err=1, rsp_data=0, err_count=1. A ret_valid arriving 2 cycles later is discarded and no rsp_valid fires. Repeating until 255 timeouts plus one more -> err_count stays 255.
- Race: ret_valid asserted in the same cycle the watchdog expires -> rsp_err=0, returned data delivered, err_count unchanged.
- Reset asserted in WAIT -> next cycle busy=0 and all outputs 0. Next request from lane 1 with lane 0 also valid -> lane 0 is granted first (ptr restored to N_REQ-1).
